// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm controller: FSM state encodings and
// packed-BCD limits used by the alarm-time editor.
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZE  = 2'b10
  } alarm_state_e;

  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
  localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
  localparam logic [7:0] BCD_ZERO     = 8'h00;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the clock/keypad side (master) and the alarm
// controller (slave): time-of-day, control levels, button pulses and the
// alarm outputs.
interface alarm_ctrl_if;
  logic       Tick;
  logic [7:0] Hour;
  logic [7:0] Minute;
  logic [7:0] Second;
  logic       AlmEn;
  logic       AlmSet;
  logic       IncH;
  logic       IncM;
  logic       Stop;
  logic [7:0] AlmHour;
  logic [7:0] AlmMin;
  logic       Ring;
  logic [1:0] State;

  modport master (
    output Tick, Hour, Minute, Second, AlmEn, AlmSet, IncH, IncM, Stop,
    input  AlmHour, AlmMin, Ring, State
  );

  modport slave (
    input  Tick, Hour, Minute, Second, AlmEn, AlmSet, IncH, IncM, Stop,
    output AlmHour, AlmMin, Ring, State
  );
endinterface

// File: rtl/alarm_ctrl_bcd_wrap_inc.sv
// bcd_wrap_inc: combinational packed-BCD +1 that wraps to 00 after MAX.
// MAX is itself a packed-BCD value (e.g. 8'h23 for hours, 8'h59 for minutes).
module bcd_wrap_inc
  import alarm_ctrl_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_MIN_MAX
) (
  input  logic [7:0] val_i,
  output logic [7:0] nxt_o
);

  // Wrap at MAX, otherwise carry the units digit into the tens digit at 9.
  always_comb begin
    nxt_o = val_i;
    if (val_i == MAX) begin
      nxt_o = BCD_ZERO;
    end else if (val_i[3:0] == 4'h9) begin
      nxt_o = {val_i[7:4] + 4'h1, 4'h0};
    end else begin
      nxt_o = {val_i[7:4], val_i[3:0] + 4'h1};
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: stores an alarm time, compares it against the running clock
// and drives a 1 s on / 1 s off buzzer for RING_SEC seconds.
// Optional feature macro: ALARM_SNOOZE_EN -- Stop while ringing snoozes for
// SNOOZE_SEC seconds instead of silencing outright.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for the alarm time (Ring low)
// ST_RINGING | buzzer active, ring_cnt_q counts elapsed seconds
// ST_SNOOZE  | buzzer silent, snz_cnt_q counts down to re-ring
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input logic         CP,
  input logic         nCR,
  alarm_ctrl_if.slave bus
);

  if (RING_SEC < 1 || RING_SEC > 255 || SNOOZE_SEC < 1 || SNOOZE_SEC > 1023) begin : g_cfg_range
    $error("alarm_ctrl: RING_SEC or SNOOZE_SEC out of range");
  end

  alarm_state_e state_q, state_d;
  logic [7:0]   ring_cnt_q, ring_cnt_d;
  logic [7:0]   alm_hour_q, alm_hour_d;
  logic [7:0]   alm_min_q, alm_min_d;
  logic [7:0]   hour_inc, min_inc;
  logic [8:0]   ring_inc;
  logic         match;
  logic         abort;
`ifdef ALARM_SNOOZE_EN
  logic [9:0]   snz_cnt_q, snz_cnt_d;
`endif

  bcd_wrap_inc #(.MAX(BCD_HOUR_MAX)) u_hour_inc (.val_i(alm_hour_q), .nxt_o(hour_inc));
  bcd_wrap_inc #(.MAX(BCD_MIN_MAX))  u_min_inc  (.val_i(alm_min_q),  .nxt_o(min_inc));

  assign match = bus.Tick && bus.AlmEn && !bus.AlmSet &&
                 (bus.Hour == alm_hour_q) && (bus.Minute == alm_min_q) &&
                 (bus.Second == BCD_ZERO);

  // Disarming or entering edit mode drops any active alarm.
  assign abort    = !bus.AlmEn || bus.AlmSet;
  assign ring_inc = {1'b0, ring_cnt_q} + 9'd1;

  // Registers: FSM state, counters and the stored alarm time.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= 8'd0;
      alm_hour_q <= BCD_ZERO;
      alm_min_q  <= BCD_ZERO;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= 10'd0;
`endif
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      alm_hour_q <= alm_hour_d;
      alm_min_q  <= alm_min_d;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= snz_cnt_d;
`endif
    end
  end

  // Next-state: alarm-time editing plus the ring/snooze sequencing.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    alm_hour_d = alm_hour_q;
    alm_min_d  = alm_min_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif

    if (bus.AlmSet) begin
      if (bus.IncH) alm_hour_d = hour_inc;
      if (bus.IncM) alm_min_d  = min_inc;
    end

    case (state_q)
      ST_IDLE: begin
        if (match) begin
          state_d    = ST_RINGING;
          ring_cnt_d = 8'd0;
        end
      end
      ST_RINGING: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bus.Stop) begin
`ifdef ALARM_SNOOZE_EN
          state_d   = ST_SNOOZE;
          snz_cnt_d = 10'(SNOOZE_SEC);
`else
          state_d   = ST_IDLE;
`endif
        end else if (bus.Tick) begin
          if (ring_inc == 9'(RING_SEC)) begin
            state_d = ST_IDLE;
          end else begin
            ring_cnt_d = ring_inc[7:0];
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (abort || bus.Stop) begin
          state_d = ST_IDLE;
        end else if (bus.Tick) begin
          // Down-counter loaded with SNOOZE_SEC; terminal count at 1.
          if (snz_cnt_q == 10'd1) begin
            state_d    = ST_RINGING;
            ring_cnt_d = 8'd0;
          end else begin
            snz_cnt_d = snz_cnt_q - 10'd1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.Ring    = (state_q == ST_RINGING) && !ring_cnt_q[0];
  assign bus.State   = state_q;
  assign bus.AlmHour = alm_hour_q;
  assign bus.AlmMin  = alm_min_q;

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60, ring duration in 1 Hz ticks (1..255).
REQ-002 Parameter SNOOZE_SEC, default 300, snooze delay in 1 Hz ticks (1..1023).
REQ-003 CP  input  1  system clock; all state changes on rising edge.
REQ-004 nCR  input  1  reset, asynchronous, active-low.
REQ-005 Tick  input  1  one-CP-cycle pulse per second, CP-synchronous.
REQ-006 Hour  input  8  current hour, packed BCD, 24 h, 8'h00..8'h23.
REQ-007 Minute  input  8  current minute, packed BCD, 8'h00..8'h59.
REQ-008 Second  input  8  current second, packed BCD, 8'h00..8'h59.
REQ-009 AlmEn  input  1  level; alarm armed when high.
REQ-010 AlmSet  input  1  level; alarm-time edit mode when high.
REQ-011 IncH, IncM  input  1 each  debounced one-cycle pulses; advance alarm hour/minute.
REQ-012 Stop  input  1  debounced one-cycle pulse; silence/snooze.
REQ-013 AlmHour, AlmMin  output  8 each  stored alarm time, packed BCD.
REQ-014 Ring  output  1  buzzer/LED drive.
REQ-015 State  output  2  2'b00 IDLE, 2'b01 RINGING, 2'b10 SNOOZE.

Function
REQ-016 AlmSet high: IncH advances AlmHour 00->23->00 BCD; IncM advances AlmMin 00->59->00 BCD; no carry from minute to hour.
REQ-017 AlmSet low: IncH/IncM ignored; IncH and IncM in same cycle both apply.
REQ-018 Match = Tick & AlmEn & ~AlmSet & Hour==AlmHour & Minute==AlmMin & Second==8'h00.
REQ-019 IDLE -> RINGING on Match; ring counter cleared to 0.
REQ-020 RINGING: ring counter increments per Tick; on reaching RING_SEC -> IDLE.
REQ-021 RINGING: Ring = 1 on even ring-counter values, 0 on odd (1 s on/1 s off beep).
REQ-022 Ring = 0 in IDLE and SNOOZE.
REQ-023 AlmEn low in any state -> IDLE next cycle, Ring 0 next cycle.
REQ-024 Stop in IDLE ignored; Stop and Match in same cycle in IDLE -> RINGING.
REQ-025 Stop and Tick in same cycle in RINGING: Stop wins, counter not advanced.
REQ-026 Entering AlmSet high while RINGING or SNOOZE -> IDLE.
REQ-027 State output registered, reflects current FSM state; 2'b11 unreachable, recovers to IDLE next cycle.

Reset
REQ-028 nCR low: State=IDLE, AlmHour=8'h00, AlmMin=8'h00, Ring=0, all counters 0, immediately without CP.
REQ-029 Reset mid-ring or mid-snooze aborts to IDLE; first cycle after release behaves as IDLE.

Configuration
REQ-030 Macro ALARM_SNOOZE_EN defined: Stop in RINGING -> SNOOZE, snooze counter cleared; counter increments per Tick; at SNOOZE_SEC -> RINGING with ring counter cleared; Stop in SNOOZE -> IDLE.
REQ-031 ALARM_SNOOZE_EN undefined: Stop in RINGING -> IDLE; SNOOZE state, snooze counter and SNOOZE_SEC logic absent; State never 2'b10.

Structure
REQ-032 Shared package holds state encodings (IDLE/RINGING/SNOOZE), BCD limits 8'h23, 8'h59, 8'h00.
REQ-033 One sub-module bcd_wrap_inc: 8-bit packed BCD increment with parameterised max, wraps to 8'h00; instantiated twice.

Verification
REQ-034 AlmSet=1, 24 IncH pulses from 8'h00 -> AlmHour returns to 8'h00 via 8'h09->8'h10, 8'h23->8'h00.
REQ-035 Alarm 07:30, AlmEn=1, time 07:30:00 with Tick -> State=01 next cycle, Ring=1; after 60 Ticks -> State=00, Ring=0.
REQ-036 Ringing, Stop pulse (snooze undefined) -> State=00 next cycle; with ALARM_SNOOZE_EN -> 10, RINGING again after 300 Ticks.
REQ-037 Time 07:30:00 with AlmSet=1 or AlmEn=0 -> State stays 00; Match at 07:30:01 -> no trigger.
REQ-038 nCR low 2 cycles mid-ring -> Ring=0, State=00, AlmHour=AlmMin=8'h00 asynchronously.
